unified_mem_arbiter: RTL and testbench

- Shares the multicycle core's single-port unified instruction/data memory between two requesters: CPU port (fetch/lw/sw traffic from the multicycle datapath) and DMA/debug port.
- Sequences each access as issue -> wait MEM_LAT -> respond.
- CPU has fixed priority; a starvation counter forces a DMA grant after STARVE_LIMIT consecutive CPU grants while DMA waits.
- The CPU controller stalls its FSM on cpu_req until cpu_ack.

---
 rtl/unified_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port unified instruction/data memory
// between the multicycle CPU and a DMA/debug requester. Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE. The CPU has fixed priority,
// but a starvation counter hands one grant to a waiting DMA after
// STARVE_LIMIT consecutive contested CPU grants.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  // DMA / debug port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  // Both limits are at most 15, so 4-bit counters suffice.
  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                we_q, we_d;          // latched direction of the transaction
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          owner_q, owner_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                grant_cpu, grant_dma;

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    owner_d      = owner_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    // strobes and acks are single-cycle pulses, low unless set below
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    grant_cpu    = 1'b0;
    grant_dma    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req && dma_req) begin
          // contested: CPU wins until DMA has waited STARVE_LIMIT grants
          if (starve_cnt_q >= STARVE_MAX) begin
            grant_dma    = 1'b1;
            starve_cnt_d = 4'd0;
          end else begin
            grant_cpu    = 1'b1;
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (cpu_req) begin
          grant_cpu    = 1'b1;
          starve_cnt_d = 4'd0;
        end else if (dma_req) begin
          grant_dma    = 1'b1;
          starve_cnt_d = 4'd0;
        end

        if (grant_cpu) begin
          we_d        = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          owner_d     = OWN_CPU;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          state_d     = ISSUE;
        end else if (grant_dma) begin
          we_d        = dma_we;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          owner_d     = OWN_DMA;
          mem_en_d    = 1'b1;
          mem_we_d    = dma_we;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = WAIT;
      end

      WAIT: begin
        if (lat_cnt_q <= 4'd1) begin
          // mem_rdata is valid this cycle; capture it and raise the ack
          // so both appear together in DONE
          lat_cnt_d = 4'd0;
          state_d   = DONE;
          if (owner_q == OWN_CPU) begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = mem_rdata;
          end else begin
            dma_ack_d = 1'b1;
            if (!we_q) dma_rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      DONE: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end

      default: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and all outputs; reset discards any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      owner_q      <= OWN_NONE;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      owner_q      <= owner_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = owner_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MEM_LAT=2 for the
// main scenarios, one at MEM_LAT=1 for the short-latency sweep. Each has a
// small memory model that drives mem_rdata only in the valid cycle.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance 0: MEM_LAT=2, STARVE_LIMIT=4
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_en, mem_we;
  logic [1:0]  owner;

  // instance 1: MEM_LAT=1, CPU side only exercised
  logic        c1_req, c1_we;
  logic [31:0] c1_addr;
  logic [31:0] u1_cpu_rdata, u1_dma_rdata, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;
  logic        u1_cpu_ack, u1_dma_ack, u1_mem_en, u1_mem_we;
  logic [1:0]  u1_owner;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIMIT(4)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(32'h0),
    .cpu_rdata(u1_cpu_rdata), .cpu_ack(u1_cpu_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(u1_dma_rdata), .dma_ack(u1_dma_ack),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(u1_mem_rdata), .owner(u1_owner)
  );

  // fixed memory contents by address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEAD_BEEF;
      32'h20:  return 32'h1234_5678;
      32'h30:  return 32'h3333_0000;
      32'h40:  return 32'h4444_0000;
      32'h04:  return 32'hA5A5_A5A5;
      default: return 32'h0;
    endcase
  endfunction

  // latency-2 memory model: data valid exactly 2 cycles after mem_en
  logic [1:0]  rv0 = 2'b00;
  logic [31:0] rd0_a = 32'h0, rd0_b = 32'h0;
  always @(posedge clk) begin
    rv0   <= {rv0[0], mem_en & ~mem_we};
    rd0_a <= mem_val(mem_addr);
    rd0_b <= rd0_a;
  end
  assign mem_rdata = rv0[1] ? rd0_b : 32'hBAD0_BAD0;

  // latency-1 memory model
  logic        rv1 = 1'b0;
  logic [31:0] rd1 = 32'h0;
  always @(posedge clk) begin
    rv1 <= u1_mem_en & ~u1_mem_we;
    rd1 <= mem_val(u1_mem_addr);
  end
  assign u1_mem_rdata = rv1 ? rd1 : 32'hBAD0_BAD0;

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset mem_en got %b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_wdata got %h want 0", mem_wdata); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset owner got %b want 00", owner); end
    checks++; if ({cpu_ack, dma_ack} !== 2'b00) begin errors++; $display("FAIL reset acks got %b want 00", {cpu_ack, dma_ack}); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset cpu_rdata got %h want 0", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL reset dma_rdata got %h want 0", dma_rdata); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({mem_en, owner} !== 3'b000) begin errors++; $display("FAIL idle_no_req en/owner got %b want 000", {mem_en, owner}); end
  endtask

  task automatic test_cpu_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (mem_en !== 1'(k == 1)) begin errors++; $display("FAIL cpu_rd mem_en cyc%0d got %b want %b", k, mem_en, k == 1); end
      checks++; if (owner !== ((k <= 4) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL cpu_rd owner cyc%0d got %b", k, owner); end
      checks++; if (cpu_ack !== 1'(k == 4) || dma_ack !== 1'b0) begin errors++; $display("FAIL cpu_rd ack cyc%0d got cpu=%b dma=%b", k, cpu_ack, dma_ack); end
      if (k == 1) begin
        checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL cpu_rd issue addr=%h we=%b want 10/0", mem_addr, mem_we); end
      end
      if (k == 4) begin
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cpu_rd data got %h want deadbeef", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_dma_write;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (mem_en !== 1'(k == 1) || mem_we !== 1'(k == 1)) begin errors++; $display("FAIL dma_wr en/we cyc%0d got %b%b", k, mem_en, mem_we); end
      checks++; if (dma_ack !== 1'(k == 4) || cpu_ack !== 1'b0) begin errors++; $display("FAIL dma_wr ack cyc%0d got dma=%b cpu=%b", k, dma_ack, cpu_ack); end
      checks++; if (cpu_rdata !== 32'hDEAD_BEEF || dma_rdata !== 32'h0) begin errors++; $display("FAIL dma_wr rdata_hold got cpu=%h dma=%h", cpu_rdata, dma_rdata); end
      if (k == 1) begin
        checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h1234_5678 || owner !== 2'b10) begin
          errors++; $display("FAIL dma_wr issue addr=%h wdata=%h owner=%b", mem_addr, mem_wdata, owner); end
      end
      if (k == 4) begin dma_req = 1'b0; dma_we = 1'b0; end
    end
  endtask

  task automatic test_simultaneous;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++; if (cpu_ack !== 1'(k == 4) || dma_ack !== 1'(k == 9)) begin errors++; $display("FAIL simul ack cyc%0d got cpu=%b dma=%b", k, cpu_ack, dma_ack); end
      if (k == 1) begin checks++; if (owner !== 2'b01) begin errors++; $display("FAIL simul first owner got %b want 01", owner); end end
      if (k == 6) begin checks++; if (owner !== 2'b10) begin errors++; $display("FAIL simul second owner got %b want 10", owner); end end
      if (k == 4) cpu_req = 1'b0;
      if (k == 9) begin
        checks++; if (dma_rdata !== 32'h1234_5678) begin errors++; $display("FAIL simul dma_rdata got %h want 12345678", dma_rdata); end
        dma_req = 1'b0;
      end
    end
  endtask

  task automatic test_starvation;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
    // grants: CPU at cycles 1,6,11,16, DMA at 21, CPU at 26; acks 3 later
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      checks++; if (cpu_ack !== 1'((k % 5 == 4) && k != 24) || dma_ack !== 1'(k == 24)) begin
        errors++; $display("FAIL starve ack cyc%0d got cpu=%b dma=%b", k, cpu_ack, dma_ack); end
      if (k % 5 == 1) begin
        checks++; if (owner !== ((k == 21) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL starve owner cyc%0d got %b", k, owner); end
      end
      if (k == 4) begin checks++; if (cpu_rdata !== 32'h3333_0000) begin errors++; $display("FAIL starve cpu_rdata got %h", cpu_rdata); end end
      if (k == 24) begin checks++; if (dma_rdata !== 32'h4444_0000) begin errors++; $display("FAIL starve dma_rdata got %h", dma_rdata); end end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    repeat (2) @(negedge clk);   // now in WAIT
    reset = 1'b1;
    #1;
    checks++; if ({mem_en, mem_we, owner, cpu_ack, dma_ack} !== 6'b0) begin errors++; $display("FAIL rst_mid ctrl got %b want 0", {mem_en, mem_we, owner, cpu_ack, dma_ack}); end
    checks++; if (mem_addr !== 32'h0 || cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid regs addr=%h cpu=%h dma=%h want 0", mem_addr, cpu_rdata, dma_rdata); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (cpu_ack !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rst_mid held ack=%b en=%b", cpu_ack, mem_en); end
    end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (cpu_ack !== 1'(k == 4) || mem_en !== 1'(k == 1)) begin errors++; $display("FAIL rst_mid fresh cyc%0d ack=%b en=%b", k, cpu_ack, mem_en); end
      if (k == 4) begin
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_mid data got %h want deadbeef", cpu_rdata); end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_mem_lat1;
    logic prev_en = 1'b0;
    @(negedge clk);
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h4;
    // two back-to-back reads: period 4, acks at cycles 3 and 7
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++; if (u1_mem_en !== 1'(k == 1 || k == 5)) begin errors++; $display("FAIL lat1 mem_en cyc%0d got %b", k, u1_mem_en); end
      checks++; if (u1_mem_en & prev_en) begin errors++; $display("FAIL lat1 consecutive mem_en cyc%0d got 1 want 0", k); end
      checks++; if (u1_cpu_ack !== 1'(k == 3 || k == 7)) begin errors++; $display("FAIL lat1 ack cyc%0d got %b", k, u1_cpu_ack); end
      if (k == 3 || k == 7) begin
        checks++; if (u1_cpu_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL lat1 data cyc%0d got %h want a5a5a5a5", k, u1_cpu_rdata); end
      end
      if (k == 7) c1_req = 1'b0;
      prev_en = u1_mem_en;
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = 32'h0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_mem_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
